// File: rtl/adc_serial_reader_pkg.sv
// Shared definitions for the ADC serial reader.
//   state_t      : FSM state encoding
//   FRAME_CLOCKS : adc_sclk periods per conversion frame
//   NULL_EDGE    : rising edge that carries the ADC null bit
package adc_serial_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] FRAME_CLOCKS = 4'd10;
    localparam logic [3:0] NULL_EDGE    = 4'd2;

endpackage

// File: rtl/adc_serial_reader_sclk_tick_gen.sv
// Half-period tick generator for adc_sclk.
// Ports:
//   clock  : system clock
//   reset  : async active-low reset
//   enable : clock-enable, counter holds when 0
//   run    : count while 1, counter forced to zero while 0
//   tick   : high in the enabled cycle that closes a CLK_DIV-cycle interval
module sclk_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    assign tick = enable && run && (cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (enable) begin
            if (!run || tick) cnt <= 8'd0;
            else              cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/adc_serial_reader.sv
// Serial reader for an 8-bit ADC frame: chip select, sclk generation and
// MSB-first capture. Frame = SETUP (CLK_DIV cycles, sclk low), then 10 sclk
// periods. Rising edge 1 is a settle edge, edge 2 the null bit, 3..10 D7..D0.
// Ports:
//   clock, reset       : system clock, async active-low reset
//   enable             : clock-enable, everything holds when 0
//   start              : level request for a frame, sampled in IDLE only
//   adc_do             : serial data from ADC
//   adc_cs_n, adc_sclk : registered ADC controls
//   data_out           : last received sample (held)
//   load               : one-cycle frame-complete strobe
//   error              : null bit was 1 in the last frame (held)
//   busy               : not in IDLE
module adc_serial_reader
    import adc_serial_reader_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic       adc_do,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [7:0] data_out,
    output logic       load,
    output logic       error,
    output logic       busy
);

    state_t     state, state_nxt;
    logic       tick;
    logic       run;
    logic [3:0] edge_cnt;   // completed falling edges in this frame
    logic [3:0] rise_no;    // index of the rising edge about to be produced
    logic [7:0] shift_reg;
    logic       null_bit;

    // DONE is excluded so the divider restarts from zero for HOLD.
    assign run     = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
    assign rise_no = edge_cnt + 4'd1;

    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .run    (run),
        .tick   (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else if (enable) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SETUP;
            ST_SETUP: if (tick) state_nxt = ST_SHIFT;
            // Leave only after the low phase following the last falling edge,
            // giving 21*CLK_DIV cycles of chip select.
            ST_SHIFT: if (tick && !adc_sclk && edge_cnt == FRAME_CLOCKS) state_nxt = ST_DONE;
            ST_DONE: begin
                state_nxt = ST_HOLD;
                load      = enable;
            end
            ST_HOLD:  if (tick) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            adc_cs_n  <= 1'b1;
            adc_sclk  <= 1'b0;
            edge_cnt  <= 4'd0;
            shift_reg <= 8'h00;
            null_bit  <= 1'b0;
            data_out  <= 8'h00;
            error     <= 1'b0;
        end else if (enable) begin
            case (state)
                ST_IDLE: begin
                    edge_cnt <= 4'd0;
                    if (start) adc_cs_n <= 1'b0;
                end
                // First rising edge: settle edge, adc_do not captured.
                ST_SETUP: if (tick) adc_sclk <= 1'b1;
                ST_SHIFT: if (tick) begin
                    if (adc_sclk) begin
                        adc_sclk <= 1'b0;
                        edge_cnt <= edge_cnt + 4'd1;
                    end else if (edge_cnt == FRAME_CLOCKS) begin
                        adc_cs_n <= 1'b1;
                        data_out <= shift_reg;
                        error    <= null_bit;
                    end else begin
                        adc_sclk <= 1'b1;
                        if (rise_no == NULL_EDGE)
                            null_bit <= adc_do;
                        else if (rise_no > NULL_EDGE)
                            shift_reg <= {shift_reg[6:0], adc_do};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_reader.sv
module tb_adc_serial_reader;

    localparam int D = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic       adc_do = 1'b0;
    logic       adc_cs_n, adc_sclk, load, error, busy;
    logic [7:0] data_out;

    always #5 clock = ~clock;

    adc_serial_reader #(.CLK_DIV(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .start    (start),
        .adc_do   (adc_do),
        .adc_cs_n (adc_cs_n),
        .adc_sclk (adc_sclk),
        .data_out (data_out),
        .load     (load),
        .error    (error),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t exp_item;

    // ADC model: presents the bit for the next rising edge shortly after
    // each rising edge (and after chip select falls, for edge 1).
    logic [7:0] adc_word = 8'h00;
    logic       adc_null = 1'b0;
    int         rise = 0;

    function automatic logic bit_for(input int e);
        if (e == 1) return 1'b1;            // settle edge: junk that must be ignored
        if (e == 2) return adc_null;
        if (e >= 3 && e <= 10) return adc_word[10 - e];
        return 1'b0;
    endfunction

    always @(posedge adc_sclk or negedge adc_cs_n) begin
        if (adc_sclk) rise = rise + 1;
        else          rise = 0;
        #1;
        adc_do = bit_for(rise + 1);
    end

    // Monitor: scoreboard pop on load, chip-select low time and gap timing.
    int   load_cnt = 0;
    int   lo = 0;
    int   hi = 0;
    logic prev_cs = 1'b1;
    bit   abort = 1'b0;
    bit   gap_chk = 1'b0;

    always @(negedge clock) begin
        if (load === 1'b1) begin
            load_cnt++;
            chk("load_only_when_enabled", {31'd0, enable}, 32'd1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: got data %0h, no frame pending", data_out);
            end else begin
                exp_item = sb.pop_front();
                chk("data_out", {24'd0, data_out}, {24'd0, exp_item.data});
                chk("error", {31'd0, error}, {31'd0, exp_item.err});
            end
        end
        if (adc_cs_n === 1'b0) begin
            if (prev_cs) begin
                if (gap_chk) chk("cs_high_gap", hi, D + 2);
                lo = 0;
            end
            if (enable) lo++;
        end else begin
            if (!prev_cs) begin
                if (!abort) chk("cs_low_time", lo, 21 * D);
                abort = 1'b0;
                hi = 0;
            end
            if (enable) hi++;
        end
        prev_cs = (adc_cs_n === 1'b0) ? 1'b0 : 1'b1;
    end

    task automatic wait_load(input string name);
        int c0 = load_cnt;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            if (load_cnt != c0) return;
        end
        chk({name, "_load_timeout"}, load_cnt, c0 + 1);
    endtask

    task automatic wait_rise(input int n);
        for (int i = 0; i < 400; i++) begin
            if (rise == n) return;
            @(posedge clock); #1;
        end
        chk("rise_timeout", rise, n);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic frame(input logic [7:0] w, input logic n, input string name);
        adc_word = w;
        adc_null = n;
        sb.push_back('{w, n});
        pulse_start();
        wait_load(name);
        repeat (D + 4) @(posedge clock);
        #1;
    endtask

    int  lc;
    int  r0;
    logic s0, c0;
    bit  found;

    initial begin
        #2 reset = 1'b0;
        @(posedge clock); #1;
        chk("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
        chk("rst_sclk", {31'd0, adc_sclk}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_load", {31'd0, load}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Basic good frame
        adc_word = 8'hA5; adc_null = 1'b0;
        sb.push_back('{8'hA5, 1'b0});
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("cs_low_after_start", {31'd0, adc_cs_n}, 32'd0);
        wait_load("a5");
        repeat (D + 4) @(posedge clock);
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Null-bit error, then recovery
        frame(8'h3C, 1'b1, "3c");
        frame(8'h01, 1'b0, "01");

        // Back-to-back frames with start held
        adc_word = 8'hFF; adc_null = 1'b0;
        sb.push_back('{8'hFF, 1'b0});
        start = 1'b1;
        wait_load("ff");
        gap_chk = 1'b1;
        adc_word = 8'h00;
        sb.push_back('{8'h00, 1'b0});
        wait_load("00");
        adc_word = 8'h80;
        sb.push_back('{8'h80, 1'b0});
        wait_load("80");
        start = 1'b0;
        repeat (D + 4) @(posedge clock);
        #1;
        gap_chk = 1'b0;

        // Reset during D4 aborts the frame
        adc_word = 8'hC3; adc_null = 1'b0;
        lc = load_cnt;
        pulse_start();
        wait_rise(6);
        @(posedge clock); #3;
        abort = 1'b1;
        reset = 1'b0;
        #1;
        chk("abort_cs_n", {31'd0, adc_cs_n}, 32'd1);
        chk("abort_sclk", {31'd0, adc_sclk}, 32'd0);
        chk("abort_load", {31'd0, load}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_data", {24'd0, data_out}, 32'd0);
        chk("abort_error", {31'd0, error}, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("abort_no_load", load_cnt, lc);
        frame(8'h55, 1'b0, "55");

        // Enable pause in SHIFT and in DONE
        adc_word = 8'h96; adc_null = 1'b0;
        sb.push_back('{8'h96, 1'b0});
        lc = load_cnt;
        pulse_start();
        wait_rise(4);
        @(posedge clock); #1;
        enable = 1'b0;
        s0 = adc_sclk; c0 = adc_cs_n; r0 = rise;
        repeat (7) begin
            @(posedge clock); #1;
            chk("pause_sclk", {31'd0, adc_sclk}, {31'd0, s0});
            chk("pause_cs_n", {31'd0, adc_cs_n}, {31'd0, c0});
        end
        chk("pause_rise", rise, r0);
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clock); #1;
            if (adc_cs_n === 1'b1 && busy === 1'b1) found = 1'b1;
        end
        chk("done_found", {31'd0, found}, 32'd1);
        enable = 1'b0;
        repeat (7) begin
            @(posedge clock); #1;
            chk("done_pause_load", {31'd0, load}, 32'd0);
            chk("done_pause_cs_n", {31'd0, adc_cs_n}, 32'd1);
        end
        chk("done_pause_no_load", load_cnt, lc);
        enable = 1'b1;
        wait_load("96");
        repeat (D + 4) @(posedge clock);
        #1;
        chk("pause_single_load", load_cnt, lc + 1);

        // start pulses while busy are ignored
        adc_word = 8'hC3; adc_null = 1'b0;
        sb.push_back('{8'hC3, 1'b0});
        lc = load_cnt;
        pulse_start();
        wait_rise(3);
        start = 1'b1;
        repeat (3) @(posedge clock);
        #1 start = 1'b0;
        wait_load("c3");
        repeat (60) @(posedge clock);
        #1;
        chk("busy_start_one_load", load_cnt, lc + 1);
        chk("busy_start_idle", {31'd0, busy}, 32'd0);
        chk("busy_start_cs_n", {31'd0, adc_cs_n}, 32'd1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
